// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad scanner slice.
//   state_e        scanner FSM state encoding
//   NUM_ROWS/COLS  matrix geometry
//   KEY_STAR/HASH  named key codes ({row_idx, col_idx})
//   col_drive()    column index -> one-hot active-low column drive pattern
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_e;

   localparam int unsigned NUM_ROWS = 4;
   localparam int unsigned NUM_COLS = 4;

   localparam logic [3:0] KEY_STAR = 4'hC;
   localparam logic [3:0] KEY_HASH = 4'hE;

   function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
      logic [NUM_COLS-1:0] one_hot;
      one_hot      = '0;
      one_hot[idx] = 1'b1;
      return ~one_hot;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: groups the scan-tick input, the keypad matrix lines and the
// key report outputs of keypad_scanner.
//   scan_tick  one-clk scan advance pulse from the prescaler
//   row_n      keypad rows, active-low
//   col_n      keypad column drive, one-hot active-low
//   key_code   last accepted key {row_idx, col_idx}
//   key_valid  one-clk pulse per accepted press
//   key_held   high while the accepted key is held
// Modports: master = the scanner, slave = its environment (prescaler, keypad, lock FSM).
interface keypad_scanner_if;

   logic       scan_tick;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  scan_tick,
      input  row_n,
      output col_n,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output scan_tick,
      output row_n,
      input  col_n,
      input  key_code,
      input  key_valid,
      input  key_held
   );

endinterface

// File: rtl/keypad_row_encoder.sv
// keypad_row_encoder: combinational priority encoder for the active-low rows.
//   row_n    in   keypad rows, active-low
//   hit      out  at least one row is low
//   row_idx  out  lowest low row index (0 when no hit)
//   multi    out  two or more rows low (ghosting / multiple keys in one column)
module keypad_row_encoder
   import keypad_pkg::*;
(
   input  logic [NUM_ROWS-1:0] row_n,
   output logic                hit,
   output logic [1:0]          row_idx,
   output logic                multi
);

   always_comb begin
      hit     = 1'b0;
      row_idx = '0;
      multi   = 1'b0;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
         if (!row_n[i]) begin
            if (hit) begin
               multi = 1'b1;
            end else begin
               row_idx = 2'(i);
            end
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad one column per scan_tick,
// debounces presses and releases, and reports one key code per physical press.
//   clk        system clock
//   reset      asynchronous, active-high reset
//   kp         keypad_scanner_if.master: scan_tick, row_n in; col_n, key_code,
//              key_valid, key_held out
// Parameter DEBOUNCE_TICKS (2..15): matching ticks needed to accept a press or release.
// Build option KEYPAD_GHOST_REJECT_EN: a column reading with two or more rows low
// never starts or continues a press debounce (it still counts as "key present"
// once a key is held).
// Rows are sampled on the tick after a column change, so the lines have a full
// tick period to settle before they are read.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 4
)(
   input logic              clk,
   input logic              reset,
   keypad_scanner_if.master kp
);

   localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic       row_hit;
   logic [1:0] row_idx;
   logic       key_ok;

`ifdef KEYPAD_GHOST_REJECT_EN
   logic row_multi;

   keypad_row_encoder u_row_enc (
      .row_n   (kp.row_n),
      .hit     (row_hit),
      .row_idx (row_idx),
      .multi   (row_multi)
   );

   assign key_ok = row_hit & ~row_multi;
`else
   logic row_multi_unused;

   keypad_row_encoder u_row_enc (
      .row_n   (kp.row_n),
      .hit     (row_hit),
      .row_idx (row_idx),
      .multi   (row_multi_unused)
   );

   assign key_ok = row_hit;
`endif

   state_e                state_q,     state_d;
   logic [1:0]            col_idx_q,   col_idx_d;
   logic [NUM_COLS-1:0]   col_n_q,     col_n_d;
   logic [3:0]            cand_q,      cand_d;
   logic [CNT_W-1:0]      deb_cnt_q,   deb_cnt_d;
   logic [3:0]            key_code_q,  key_code_d;
   logic                  key_valid_q, key_valid_d;
   logic                  key_held_q,  key_held_d;

   logic [3:0] code_now;
   assign code_now = {row_idx, col_idx_q};

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      col_n_d     = col_n_q;
      cand_d      = cand_q;
      deb_cnt_d   = deb_cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      if (kp.scan_tick) begin
         unique case (state_q)
            SCAN: begin
               if (key_ok) begin
                  cand_d    = code_now;
                  deb_cnt_d = CNT_ONE;
                  state_d   = DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
                  col_n_d   = col_drive(col_idx_q + 2'd1);
               end
            end
            DEBOUNCE: begin
               if (key_ok && (code_now == cand_q)) begin
                  // Accept on the edge that would make the count reach the
                  // limit, so the counter itself never holds DEBOUNCE_TICKS.
                  if (deb_cnt_q == CNT_LAST) begin
                     key_code_d  = cand_q;
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     deb_cnt_d   = '0;
                     state_d     = HELD;
                  end else begin
                     deb_cnt_d = deb_cnt_q + CNT_ONE;
                  end
               end else begin
                  // Column stays put so the same key can be re-detected.
                  deb_cnt_d = '0;
                  state_d   = SCAN;
               end
            end
            HELD: begin
               if (!row_hit) begin
                  deb_cnt_d = CNT_ONE;
                  state_d   = RELEASE;
               end
            end
            RELEASE: begin
               if (row_hit) begin
                  deb_cnt_d = '0;
                  state_d   = HELD;
               end else if (deb_cnt_q == CNT_LAST) begin
                  key_held_d = 1'b0;
                  deb_cnt_d  = '0;
                  col_idx_d  = col_idx_q + 2'd1;
                  col_n_d    = col_drive(col_idx_q + 2'd1);
                  state_d    = SCAN;
               end else begin
                  deb_cnt_d = deb_cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = SCAN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SCAN;
         col_idx_q   <= '0;
         col_n_q     <= 4'b1110;
         cand_q      <= '0;
         deb_cnt_q   <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         col_n_q     <= col_n_d;
         cand_q      <= cand_d;
         deb_cnt_q   <= deb_cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign kp.col_n     = col_n_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner (DEBOUNCE_TICKS = 4).
// A small keypad model pulls the masked rows low only while the pressed key's
// column is driven. Expected key codes are queued when a press is expected to be
// accepted; a monitor pops one entry per key_valid pulse.
module tb_keypad_scanner;
   import keypad_pkg::*;

   logic clk;
   logic reset;
   logic scan_tick;

   logic       key_down;
   logic [1:0] key_col;
   logic [3:0] row_mask;

   int checks;
   int errors;
   int valid_seen;

   logic [3:0] exp_q[$];

   keypad_scanner_if kp_if ();

   assign kp_if.scan_tick = scan_tick;
   assign kp_if.row_n     = (key_down && (kp_if.col_n[key_col] == 1'b0)) ? ~row_mask : 4'hF;

   keypad_scanner #(.DEBOUNCE_TICKS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One scan tick, then two idle clocks so single-clk pulses are observable.
   task automatic tick();
      @(negedge clk) scan_tick = 1'b1;
      @(negedge clk) scan_tick = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press(input logic [1:0] row, input logic [1:0] col);
      row_mask = '0;
      row_mask[row] = 1'b1;
      key_col  = col;
      key_down = 1'b1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset && kp_if.key_valid) begin
         logic [3:0] exp_code;
         valid_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_key_valid: got code %h expected no pulse", kp_if.key_code);
         end else begin
            exp_code = exp_q.pop_front();
            if (kp_if.key_code !== exp_code || kp_if.key_held !== 1'b1) begin
               errors++;
               $display("FAIL key_report: got code %h held %b expected code %h held 1",
                        kp_if.key_code, kp_if.key_held, exp_code);
            end
         end
      end
   end

   initial begin
      int vs;
      logic [1:0] idx;
      checks     = 0;
      errors     = 0;
      valid_seen = 0;
      reset      = 1'b1;
      scan_tick  = 1'b0;
      key_down   = 1'b0;
      key_col    = '0;
      row_mask   = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset values
      check("reset_col_n", kp_if.col_n, 4'b1110);
      check("reset_key_code", kp_if.key_code, 4'h0);
      check("reset_valid_held", {2'b00, kp_if.key_valid, kp_if.key_held}, 4'b0000);

      // 1: idle scanning walks the columns
      for (int i = 1; i <= 10; i++) begin
         tick();
         idx = 2'(i % 4);
         check($sformatf("scan_col_%0d", i), kp_if.col_n, col_drive(idx));
      end
      check("idle_no_valid", 4'(valid_seen), 4'd0);

      // 2: row 1 on column 2 -> code 6 after 4 ticks
      press(2'd1, 2'd2);
      ticks(3);
      check("press_not_yet", 4'(valid_seen), 4'd0);
      check("press_col_frozen", kp_if.col_n, 4'b1011);
      exp_q.push_back(4'h6);
      tick();
      check("press_one_valid", 4'(valid_seen), 4'd1);
      check("press_held", {3'b000, kp_if.key_held}, 4'd1);
      check("press_code", kp_if.key_code, 4'h6);

      // 4: long hold, then release with a one-tick re-press bounce
      ticks(50);
      check("hold_no_repeat", 4'(valid_seen), 4'd1);
      check("hold_col_frozen", kp_if.col_n, 4'b1011);
      key_down = 1'b0;
      ticks(2);
      key_down = 1'b1;
      tick();
      key_down = 1'b0;
      ticks(3);
      check("release_held_3", {3'b000, kp_if.key_held}, 4'd1);
      tick();
      check("release_held_4", {3'b000, kp_if.key_held}, 4'd0);
      check("release_col_adv", kp_if.col_n, 4'b0111);
      check("release_no_valid", 4'(valid_seen), 4'd1);
      check("release_code_kept", kp_if.key_code, 4'h6);

      // 3: bounce on row 2 / column 0 (code 8)
      press(2'd2, 2'd0);
      tick();
      check("bounce_col0", kp_if.col_n, 4'b1110);
      ticks(2);
      key_down = 1'b0;
      tick();
      check("bounce_col_kept", kp_if.col_n, 4'b1110);
      check("bounce_no_pulse", 4'(valid_seen), 4'd1);
      key_down = 1'b1;
      ticks(3);
      check("bounce_not_yet", 4'(valid_seen), 4'd1);
      exp_q.push_back(4'h8);
      tick();
      check("bounce_one_pulse", 4'(valid_seen), 4'd2);
      key_down = 1'b0;
      ticks(4);
      check("bounce_released", {3'b000, kp_if.key_held}, 4'd0);
      check("bounce_col_adv", kp_if.col_n, 4'b1101);

      // 5: async reset on the third debounce tick of row 3 / column 1
      press(2'd3, 2'd1);
      ticks(3);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("areset_col_n", kp_if.col_n, 4'b1110);
      check("areset_code", kp_if.key_code, 4'h0);
      check("areset_valid_held", {2'b00, kp_if.key_valid, kp_if.key_held}, 4'b0000);
      key_down = 1'b0;
      @(negedge clk) reset = 1'b0;
      vs = valid_seen;
      ticks(6);
      check("areset_no_valid", 4'(valid_seen - vs), 4'd0);
      check("areset_col", kp_if.col_n, 4'b1011);

      // 6: two rows low on column 0 (row_n = 1100)
      row_mask = 4'b0011;
      key_col  = 2'd0;
      key_down = 1'b1;
      ticks(2);
      check("ghost_col0", kp_if.col_n, 4'b1110);
      vs = valid_seen;
`ifdef KEYPAD_GHOST_REJECT_EN
      tick();
      check("ghost_scan_continues", kp_if.col_n, 4'b1101);
      ticks(3);
      check("ghost_no_valid", 4'(valid_seen - vs), 4'd0);
      key_down = 1'b0;
      ticks(4);
`else
      exp_q.push_back(4'h0);
      ticks(4);
      check("ghost_priority_valid", 4'(valid_seen - vs), 4'd1);
      check("ghost_priority_code", kp_if.key_code, 4'h0);
      key_down = 1'b0;
      ticks(4);
`endif
      check("final_held", {3'b000, kp_if.key_held}, 4'd0);
      check("final_queue_empty", 4'(exp_q.size()), 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
